// File: rtl/kyber_pkg.sv
// kyber_pkg
// Shared constants for the Kyber A-matrix front end: sequencer state
// encoding, field modulus, seed and XOF input widths and the default
// matrix dimension. No ports.
package kyber_pkg;

  localparam int KYBER_Q     = 3329;
  localparam int SEED_BITS   = 256;
  localparam int XOF_IN_BITS = 272;
  localparam int DEFAULT_K   = 3;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEAR = 3'd1;
  localparam logic [STATE_W-1:0] ST_KICK  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_NEXT  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/a_matrix_seq_idx_counter.sv
// a_idx_counter
// Nested row/column counter for walking a KxK matrix in row-major order.
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset
//   clear_i   return to entry (0,0)
//   advance_i step to the next entry (column inner, row outer)
//   row_o     current row index i
//   col_o     current column index j
//   last_o    high while the current entry is (K-1,K-1)
module a_idx_counter #(
  parameter int K     = 3,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic             last_o
);

  logic [IDX_W-1:0] rowQ;
  logic [IDX_W-1:0] colQ;

  // Column wraps to zero and carries into the row. Advancing past the last
  // entry leaves the row out of range, which is harmless because the
  // sequencer finishes there and clears before the next walk.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      rowQ <= '0;
      colQ <= '0;
    end else if (advance_i) begin
      if (colQ == IDX_W'(K - 1)) begin
        colQ <= '0;
        rowQ <= rowQ + 1'b1;
      end else begin
        colQ <= colQ + 1'b1;
      end
    end
  end

  assign row_o  = rowQ;
  assign col_o  = colQ;
  assign last_o = (rowQ == IDX_W'(K - 1)) && (colQ == IDX_W'(K - 1));

endmodule

// File: rtl/a_matrix_seq.sv
// a_matrix_seq
// Sequencer that drives the A-matrix parse/XOF generator over all KxK
// entries in row-major order. For each entry it builds rho||j||i (or
// rho||i||j when transposed), clears and kicks the generator, selects the
// RAM bank and counts the generator's coefficient-word strobes.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        request a full matrix (ignored while busy)
//   transpose    index byte order, captured on accepted start
//   rho          256-bit seed, captured on accepted start
//   gen_enw      generator write strobe
//   gen_M        272-bit XOF input to the generator
//   gen_active   generator start, held until its first strobe
//   gen_rst      active-high generator clear
//   gen_offset   RAM write start offset (constant BASE_OFFSET)
//   poly_idx     RAM bank select i*K+j
//   busy, done   sequence in progress / one-cycle completion pulse
//   err          watchdog error
// Optional feature: define A_MATRIX_SEQ_TIMEOUT_EN to enable the KICK/WAIT
// watchdog; without it err is tied low and the sequencer waits forever.
module a_matrix_seq
  import kyber_pkg::*;
#(
  parameter int         K              = DEFAULT_K,
  parameter int         WORDS_PER_POLY = 32,
  parameter logic [7:0] BASE_OFFSET    = 8'd0,
  parameter int         TIMEOUT_CYC    = 4095
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           transpose,
  input  logic [255:0]   rho,
  input  logic           gen_enw,
  output logic [271:0]   gen_M,
  output logic           gen_active,
  output logic           gen_rst,
  output logic [7:0]     gen_offset,
  output logic [3:0]     poly_idx,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int CNT_W = $clog2(WORDS_PER_POLY + 1);

  logic [STATE_W-1:0]     stateQ, stateD;
  logic [CNT_W-1:0]       wordCntQ, wordCntD;
  logic [SEED_BITS-1:0]   rhoQ;
  logic                   transposeQ;
  logic [XOF_IN_BITS-1:0] genMQ;
  logic [3:0]             polyIdxQ;
  logic                   idxClear;
  logic                   idxAdvance;
  logic                   idxLast;
  logic [3:0]             rowIdx;
  logic [3:0]             colIdx;
  logic                   timeoutHit;

  a_idx_counter #(
    .K     (K),
    .IDX_W (4)
  ) uIdx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (idxClear),
    .advance_i (idxAdvance),
    .row_o     (rowIdx),
    .col_o     (colIdx),
    .last_o    (idxLast)
  );

`ifdef A_MATRIX_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wdogQ;
  logic          errQ;

  // A strobe in the same cycle as the limit counts as progress, so the
  // watchdog only fires on a genuinely silent generator.
  assign timeoutHit = ((stateQ == ST_KICK) || (stateQ == ST_WAIT)) &&
                      !gen_enw && (wdogQ >= TW'(TIMEOUT_CYC));

  // Watchdog restarts on the way into KICK and on every strobe; err is
  // sticky until reset or the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdogQ <= '0;
      errQ  <= 1'b0;
    end else begin
      if ((stateQ == ST_CLEAR) || gen_enw) begin
        wdogQ <= '0;
      end else if (((stateQ == ST_KICK) || (stateQ == ST_WAIT)) &&
                   (wdogQ < TW'(TIMEOUT_CYC))) begin
        wdogQ <= wdogQ + 1'b1;
      end
      if ((stateQ == ST_IDLE) && start) begin
        errQ <= 1'b0;
      end else if (timeoutHit) begin
        errQ <= 1'b1;
      end
    end
  end

  assign err = errQ;
`else
  assign timeoutHit = 1'b0;
  assign err        = 1'b0;
`endif

  // Next-state logic. The entry counter steps in NEXT using the indices of
  // the entry that just finished, so idxLast there means the whole matrix
  // is complete.
  always_comb begin
    stateD     = stateQ;
    wordCntD   = wordCntQ;
    idxClear   = 1'b0;
    idxAdvance = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (start) begin
          idxClear = 1'b1;
          stateD   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        wordCntD = '0;
        stateD   = ST_KICK;
      end
      ST_KICK: begin
        if (timeoutHit) begin
          stateD = ST_DONE;
        end else if (gen_enw) begin
          wordCntD = CNT_W'(1);
          stateD   = (WORDS_PER_POLY == 1) ? ST_NEXT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timeoutHit) begin
          stateD = ST_DONE;
        end else if (gen_enw) begin
          wordCntD = wordCntQ + 1'b1;
          if (wordCntQ + 1'b1 == CNT_W'(WORDS_PER_POLY)) begin
            stateD = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        idxAdvance = 1'b1;
        stateD     = idxLast ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: begin
        stateD = ST_IDLE;
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // State, word count and captured request. Seed and transpose are only
  // taken on an accepted start so a start while busy cannot disturb them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ     <= ST_IDLE;
      wordCntQ   <= '0;
      rhoQ       <= '0;
      transposeQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      wordCntQ <= wordCntD;
      if ((stateQ == ST_IDLE) && start) begin
        rhoQ       <= rho;
        transposeQ <= transpose;
      end
    end
  end

  // XOF input and bank select are refreshed in CLEAR so they are stable
  // from KICK onwards while the generator absorbs them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      genMQ    <= '0;
      polyIdxQ <= '0;
    end else if (stateQ == ST_CLEAR) begin
      if (transposeQ) begin
        genMQ <= {4'b0, colIdx, 4'b0, rowIdx, rhoQ};
      end else begin
        genMQ <= {4'b0, rowIdx, 4'b0, colIdx, rhoQ};
      end
      polyIdxQ <= 4'(rowIdx * 4'(K)) + colIdx;
    end
  end

  assign gen_M      = genMQ;
  assign poly_idx   = polyIdxQ;
  assign gen_offset = BASE_OFFSET;
  assign gen_active = (stateQ == ST_KICK);
  assign gen_rst    = (stateQ == ST_IDLE) || (stateQ == ST_CLEAR) ||
                      (stateQ == ST_DONE);
  assign busy       = (stateQ != ST_IDLE);
  assign done       = (stateQ == ST_DONE);

endmodule
